// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyser capture sequencer.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_READ,
        ST_FLUSH
    } la_state_t;

    localparam int LA_ADDR_WIDTH = 12;
    localparam int DEPTH         = 2 ** LA_ADDR_WIDTH;

    // Total length is forced into [1, depth]; zero still captures the trigger sample.
    function automatic logic [31:0] clamp_total(input logic [31:0] len, input logic [31:0] depth);
        logic [31:0] t;
        t = (len > depth) ? depth : len;
        return (t == 32'd0) ? 32'd1 : t;
    endfunction

    function automatic logic [31:0] clamp_pre(input logic [31:0] pre, input logic [31:0] total);
        return (pre > total - 32'd1) ? total - 32'd1 : pre;
    endfunction

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Bundle of the sample-FIFO control/status signals; the sequencer is the master.
interface la_fifo_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_wen;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic                  fifo_ren;
    logic [ADDR_WIDTH:0]   fifo_level;
    logic                  fifo_alfull;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_dout;

    modport master (
        output fifo_wen, fifo_din, fifo_ren, fifo_level,
        input  fifo_alfull, fifo_empty, fifo_full, fifo_dout
    );

    modport slave (
        input  fifo_wen, fifo_din, fifo_ren, fifo_level,
        output fifo_alfull, fifo_empty, fifo_full, fifo_dout
    );
endinterface

// File: rtl/la_rd_port.sv
// Host read handshake over the FIFO: one pop per accepted request, registered data.
// In flush mode it pops every non-empty cycle and never raises rd_valid.
module la_rd_port #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic                  flush_en,
    input  logic                  rd_req,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  pop,
    output logic                  outstanding,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic host_pend;

    assign pop = !fifo_empty && ((read_en && rd_req && !outstanding) || flush_en);

    // A host read is only delivered if the port is still in read mode when the data lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
            host_pend   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            outstanding <= pop;
            host_pend   <= pop && read_en;
            rd_valid    <= host_pend && read_en;
            if (host_pend && read_en) begin
                rd_data <= fifo_dout;
            end
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: fills the sample FIFO with pre-trigger history, the trigger
// sample and post-trigger samples, then drains it through the host read port.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int ADDR_WIDTH = LA_ADDR_WIDTH,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   pre_len,
    input  logic [ADDR_WIDTH:0]   total_len,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] sample_din,
    input  logic                  trig_hit,
    la_fifo_if.master             fifo,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   trig_pos,
    output logic                  overflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FIFO_DEPTH = CW'(2 ** ADDR_WIDTH);

    la_state_t     state, state_nxt;
    logic [CW-1:0] t_len, p_len, occ, wcnt;
    logic [CW-1:0] t_arm, p_arm;
    logic          arm_go, abort_go, sample_ok;
    logic          want_wen, want_pop, trig_fire;
    logic          cap_pop, rd_pop, rd_outstanding;
    logic          read_en, flush_en;

    assign t_arm     = CW'(clamp_total(32'(total_len), 32'(FIFO_DEPTH)));
    assign p_arm     = CW'(clamp_pre(32'(pre_len), 32'(t_arm)));
    assign abort_go  = abort && (state != ST_IDLE);
    assign arm_go    = arm && !abort && (state == ST_IDLE);
    assign sample_ok = sample_en && !abort;

    // The trigger sample itself may complete the capture when P = T-1 (T = 1 included).
    always_comb begin
        state_nxt = state;
        want_wen  = 1'b0;
        want_pop  = 1'b0;
        trig_fire = 1'b0;
        if (abort_go) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_go) state_nxt = (p_arm != '0) ? ST_PRE : ST_WAIT;
                end
                ST_PRE: begin
                    if (sample_ok) begin
                        want_wen = 1'b1;
                        if (occ + CW'(1) == p_len) state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sample_ok && trig_hit) begin
                        want_wen  = 1'b1;
                        trig_fire = 1'b1;
                        state_nxt = (p_len + CW'(1) == t_len) ? ST_READ : ST_POST;
                    end else if (sample_ok && p_len != '0) begin
                        want_wen = 1'b1;
                        want_pop = 1'b1;
                    end
                end
                ST_POST: begin
                    if (sample_ok) begin
                        want_wen = 1'b1;
                        if (p_len + wcnt + CW'(1) == t_len) state_nxt = ST_READ;
                    end
                end
                ST_READ, ST_FLUSH: begin
                    if (fifo.fifo_empty && !rd_outstanding) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign cap_pop  = want_pop && !fifo.fifo_full && !fifo.fifo_empty;
    assign read_en  = (state == ST_READ) && !abort;
    assign flush_en = (state == ST_FLUSH);

    assign fifo.fifo_wen   = want_wen && !fifo.fifo_full;
    assign fifo.fifo_ren   = cap_pop || rd_pop;
    assign fifo.fifo_din   = sample_din;
    assign fifo.fifo_level = p_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            t_len     <= '0;
            p_len     <= '0;
            occ       <= '0;
            wcnt      <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arm_go) begin
                t_len     <= t_arm;
                p_len     <= p_arm;
                occ       <= '0;
                wcnt      <= '0;
                triggered <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (fifo.fifo_wen && !fifo.fifo_ren) begin
                    occ <= occ + CW'(1);
                end else if (!fifo.fifo_wen && fifo.fifo_ren) begin
                    occ <= occ - CW'(1);
                end
                if (trig_fire) begin
                    triggered <= 1'b1;
                    wcnt      <= CW'(1);
                end else if (state == ST_POST && fifo.fifo_wen) begin
                    wcnt <= wcnt + CW'(1);
                end
                if (want_wen && fifo.fifo_full) overflow <= 1'b1;
                if (abort_go) begin
                    triggered <= 1'b0;
                    wcnt      <= '0;
                end
            end
        end
    end

    la_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_rd_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_en     (read_en),
        .flush_en    (flush_en),
        .rd_req      (rd_req),
        .fifo_empty  (fifo.fifo_empty),
        .fifo_dout   (fifo.fifo_dout),
        .pop         (rd_pop),
        .outstanding (rd_outstanding),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data)
    );

    assign busy     = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST) || (state == ST_FLUSH);
    assign done     = (state == ST_READ);
    assign trig_pos = p_len;

    // While sliding the pre-trigger window the FIFO must sit at its threshold.
    wait_alfull_chk: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_WAIT && p_len != '0) |-> fifo.fifo_alfull);

endmodule
